// File: rtl/bram_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter_if
// Bundles the two requester ports (m0 = core memory stage, m1 = loader/debug)
// and the RAM-side port of the single-port block RAM arbiter.
//
// Signals per requester (mX_*):
//   req    : request, held with fields stable until gnt
//   we     : 1 = write, 0 = read
//   addr   : word address (AW bits)
//   wdata  : write data (DW bits)
//   gnt    : one-cycle accept pulse (combinational in the arbiter)
//   rvalid : one-cycle read-data pulse
//   rdata  : read data, held until the next read for that port completes
// RAM side:
//   ram_wea, ram_addra, ram_dina : registered drives into the RAM
//   ram_douta                    : RAM read data
// Status:
//   busy : arbiter FSM is not idle
//
// Modports:
//   master : requester/system view (drives requests and RAM read data)
//   slave  : arbiter view
// -----------------------------------------------------------------------------
interface bram_port_arbiter_if #(
    parameter int unsigned AW = 7,
    parameter int unsigned DW = 32
);
    // Requester 0
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    // Requester 1
    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    // RAM side
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_dina;
    logic [DW-1:0] ram_douta;

    // Status
    logic          busy;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output ram_douta,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_wea, ram_addra, ram_dina,
        input  busy
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  ram_douta,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_wea, ram_addra, ram_dina,
        output busy
    );

endinterface

// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
// Shares one single-port block RAM (AW x DW) between two requesters with
// one transaction in flight at a time. Arbitration is round-robin or fixed
// priority (m0 wins). All RAM-side drives come straight from registers that
// change only on the edges entering or leaving ACCESS, giving the RAM a full
// clock period of setup/hold around its capture edge.
//
// Parameters:
//   AW         : RAM address width
//   DW         : RAM data width
//   RD_LAT     : RAM read latency in cycles (legal 1..4)
//   FIXED_PRIO : 1 = m0 always wins contention, 0 = round-robin
//
// Ports:
//   clka : clock, everything on the rising edge
//   rsta : synchronous active-high reset
//   bus  : requester + RAM bundle (slave view)
//
// Transaction timing (grant in cycle 0):
//   write : ram_wea high in cycle 1, next grant possible in cycle 2
//   read  : ACCESS cycle 1, WAIT cycles 2..1+RD_LAT, rvalid in 2+RD_LAT
// -----------------------------------------------------------------------------
module bram_port_arbiter #(
    parameter int unsigned AW         = 7,
    parameter int unsigned DW         = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic                clka,
    input  logic                rsta,
    bram_port_arbiter_if.slave  bus
);

    // Wide enough for RD_LAT up to 4.
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last;
    logic          owner;
    logic          cap_we;

    logic          m0_rvalid;
    logic          m1_rvalid;
    logic [DW-1:0] m0_rdata;
    logic [DW-1:0] m1_rdata;
    logic          ram_wea;
    logic [AW-1:0] ram_addra;
    logic [DW-1:0] ram_dina;
    logic          busy;

    logic          pick1;
    logic          grant;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // Arbitration: choose the winning port and mux its request fields.
    always_comb begin
        pick1     = 1'b0;
        grant     = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;

        // On contention round-robin hands the grant to the port that did not
        // win last time; a sole requester always wins.
        if (bus.m0_req && bus.m1_req) begin
            pick1 = FIXED_PRIO ? 1'b0 : ~last;
        end else begin
            pick1 = bus.m1_req;
        end

        // Grant is suppressed while reset is asserted.
        grant = (state == IDLE) && !rsta && (bus.m0_req || bus.m1_req);

        if (pick1) begin
            sel_we    = bus.m1_we;
            sel_addr  = bus.m1_addr;
            sel_wdata = bus.m1_wdata;
        end else begin
            sel_we    = bus.m0_we;
            sel_addr  = bus.m0_addr;
            sel_wdata = bus.m0_wdata;
        end
    end

    // Sequencer: IDLE -> ACCESS -> (write) IDLE | (read) WAIT x RD_LAT -> IDLE.
    always_ff @(posedge clka) begin
        if (rsta) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 1'b1;
            owner     <= 1'b0;
            cap_we    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            ram_wea   <= 1'b0;
            ram_addra <= '0;
            ram_dina  <= '0;
            busy      <= 1'b0;
        end else begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (grant) begin
                        owner     <= pick1;
                        last      <= pick1;
                        cap_we    <= sel_we;
                        // RAM drives load on the edge entering ACCESS.
                        ram_wea   <= sel_we;
                        ram_addra <= sel_addr;
                        ram_dina  <= sel_wdata;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end

                ACCESS: begin
                    // Address/data stay put; only the write strobe drops.
                    ram_wea <= 1'b0;
                    if (cap_we) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt   <= CW'(RD_LAT);
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    cnt <= cnt - CW'(1);
                    // Last WAIT cycle: RAM output is valid now.
                    if (cnt == CW'(1)) begin
                        if (owner) begin
                            m1_rdata  <= bus.ram_douta;
                            m1_rvalid <= 1'b1;
                        end else begin
                            m0_rdata  <= bus.ram_douta;
                            m0_rvalid <= 1'b1;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.m0_gnt    = grant & ~pick1;
    assign bus.m1_gnt    = grant &  pick1;
    assign bus.m0_rvalid = m0_rvalid;
    assign bus.m1_rvalid = m1_rvalid;
    assign bus.m0_rdata  = m0_rdata;
    assign bus.m1_rdata  = m1_rdata;
    assign bus.ram_wea   = ram_wea;
    assign bus.ram_addra = ram_addra;
    assign bus.ram_dina  = ram_dina;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_port_arbiter
// Scoreboard bench for bram_port_arbiter. A round-robin instance runs against
// a behavioural RD_LAT-deep RAM; a fixed-priority instance checks grant
// ownership. Read expectations are queued per port from a shadow memory when
// a read is driven and popped when that port's rvalid fires.
// -----------------------------------------------------------------------------
module tb_bram_port_arbiter;

    localparam int unsigned AW     = 7;
    localparam int unsigned DW     = 32;
    localparam int unsigned RD_LAT = 1;

    logic clka = 1'b0;
    logic rsta;
    int   cyc  = 0;

    always #5 clka = ~clka;
    always @(posedge clka) cyc <= cyc + 1;

    bram_port_arbiter_if #(.AW(AW), .DW(DW)) bus    ();
    bram_port_arbiter_if #(.AW(AW), .DW(DW)) bus_fp ();

    bram_port_arbiter #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .FIXED_PRIO(1'b0)
    ) dut (
        .clka (clka),
        .rsta (rsta),
        .bus  (bus)
    );

    bram_port_arbiter #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .FIXED_PRIO(1'b1)
    ) dut_fp (
        .clka (clka),
        .rsta (rsta),
        .bus  (bus_fp)
    );

    // Behavioural single-port RAM with RD_LAT output stages.
    logic [DW-1:0] mem  [2**AW];
    logic [DW-1:0] pipe [RD_LAT];

    always @(posedge clka) begin
        if (bus.ram_wea) mem[bus.ram_addra] <= bus.ram_dina;
        pipe[0] <= mem[bus.ram_addra];
        for (int i = 1; i < int'(RD_LAT); i++) pipe[i] <= pipe[i-1];
    end
    assign bus.ram_douta    = pipe[RD_LAT-1];
    assign bus_fp.ram_douta = '0;

    // Scoreboard state
    logic [DW-1:0] shadow [2**AW];
    logic [DW-1:0] exp_q0 [$];
    logic [DW-1:0] exp_q1 [$];
    int            rd_gcyc0 [$];
    int            rd_gcyc1 [$];
    int            gnt_port_q [$];
    int            gnt_cyc_q  [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor for the round-robin instance.
    logic [DW-1:0] mon_e;
    int            mon_g;
    always @(negedge clka) begin
        if (rsta) begin
            rd_gcyc0.delete();
            rd_gcyc1.delete();
        end
        if (bus.m0_gnt || bus.m1_gnt) begin
            check("gnt_onehot", 64'(bus.m0_gnt & bus.m1_gnt), 64'(0));
            if (bus.m0_gnt) begin
                gnt_port_q.push_back(0);
                gnt_cyc_q.push_back(cyc);
                if (!bus.m0_we) rd_gcyc0.push_back(cyc);
            end else begin
                gnt_port_q.push_back(1);
                gnt_cyc_q.push_back(cyc);
                if (!bus.m1_we) rd_gcyc1.push_back(cyc);
            end
        end
        if (bus.m0_rvalid) begin
            if (exp_q0.size() == 0) begin
                check("m0_rvalid_unexpected", 64'(1), 64'(0));
            end else begin
                mon_e = exp_q0.pop_front();
                check("m0_rdata", 64'(bus.m0_rdata), 64'(mon_e));
            end
            if (rd_gcyc0.size() != 0) begin
                mon_g = rd_gcyc0.pop_front();
                check("m0_rd_latency", 64'(cyc - mon_g), 64'(2 + RD_LAT));
            end
        end
        if (bus.m1_rvalid) begin
            if (exp_q1.size() == 0) begin
                check("m1_rvalid_unexpected", 64'(1), 64'(0));
            end else begin
                mon_e = exp_q1.pop_front();
                check("m1_rdata", 64'(bus.m1_rdata), 64'(mon_e));
            end
            if (rd_gcyc1.size() != 0) begin
                mon_g = rd_gcyc1.pop_front();
                check("m1_rd_latency", 64'(cyc - mon_g), 64'(2 + RD_LAT));
            end
        end
    end

    // Raise a request; writes update the shadow, reads optionally queue an expectation.
    task automatic drive(input int p, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input bit expect_rd);
        if (we) shadow[addr] = wd;
        else if (expect_rd) begin
            if (p == 0) exp_q0.push_back(shadow[addr]);
            else        exp_q1.push_back(shadow[addr]);
        end
        if (p == 0) begin
            bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wd; bus.m0_req = 1'b1;
        end else begin
            bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wd; bus.m1_req = 1'b1;
        end
    endtask

    task automatic drop(input int p);
        @(posedge clka);
        #1;
        if (p == 0) bus.m0_req = 1'b0;
        else        bus.m1_req = 1'b0;
    endtask

    // Wait (bounded) for this port's grant, then release the request.
    task automatic wait_gnt(input int p);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clka);
            got = (p == 0) ? bus.m0_gnt : bus.m1_gnt;
        end
        check((p == 0) ? "m0_gnt_wait" : "m1_gnt_wait", 64'(got), 64'(1));
        drop(p);
    endtask

    task automatic req_port(input int p, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input bit expect_rd);
        drive(p, we, addr, wd, expect_rd);
        wait_gnt(p);
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clka);
            done = (exp_q0.size() == 0) && (exp_q1.size() == 0) && !bus.busy;
        end
        check("drain", 64'(done), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int idx;
    int n0;
    int n1;

    initial begin
        rsta = 1'b1;
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
        bus_fp.m0_req = 1'b0; bus_fp.m0_we = 1'b1; bus_fp.m0_addr = '0; bus_fp.m0_wdata = '0;
        bus_fp.m1_req = 1'b0; bus_fp.m1_we = 1'b1; bus_fp.m1_addr = '0; bus_fp.m1_wdata = '0;

        // Reset with both ports requesting: no grant, all outputs zero.
        drive(0, 1'b1, 7'd3, 32'hA0A0_0003, 1'b0);
        drive(1, 1'b1, 7'd4, 32'hB0B0_0004, 1'b0);
        repeat (3) begin
            @(negedge clka);
            check("rst_ctrl", 64'({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid,
                                   bus.ram_wea, bus.busy}), 64'(0));
            check("rst_ram", 64'({bus.ram_addra, bus.ram_dina}), 64'(0));
            check("rst_rdata", {bus.m0_rdata, bus.m1_rdata}, 64'(0));
        end
        @(posedge clka);
        #1 rsta = 1'b0;
        @(negedge clka);
        check("rel_m0_gnt", 64'({bus.m0_gnt, bus.m1_gnt}), 64'(2'b10));
        check("rel_ctrl", 64'({bus.m0_rvalid, bus.m1_rvalid, bus.ram_wea, bus.busy}), 64'(0));
        check("rel_rdata", {bus.m0_rdata, bus.m1_rdata}, 64'(0));
        drop(0);
        wait_gnt(1);

        // Write then read the same address on m0.
        req_port(0, 1'b1, 7'd5, 32'hDEAD_BEEF, 1'b0);
        @(negedge clka);
        check("wr_wea_on", 64'(bus.ram_wea), 64'(1));
        check("wr_addr", 64'(bus.ram_addra), 64'(5));
        check("wr_dina", 64'(bus.ram_dina), 64'(32'hDEAD_BEEF));
        drive(0, 1'b0, 7'd5, 32'h0, 1'b1);
        @(negedge clka);
        check("wr_wea_off", 64'(bus.ram_wea), 64'(0));
        check("wr_next_gnt", 64'(bus.m0_gnt), 64'(1));
        drop(0);

        // Seed m1's data; also leaves m1 as the most recent winner.
        req_port(1, 1'b1, 7'd9, 32'h1111_2222, 1'b0);

        // Contention: two rounds of simultaneous reads.
        idx = gnt_port_q.size();
        for (int r = 0; r < 2; r++) begin
            fork
                req_port(0, 1'b0, 7'd5, 32'h0, 1'b1);
                req_port(1, 1'b0, 7'd9, 32'h0, 1'b1);
            join
        end
        check("rr_gnt_count", 64'(gnt_port_q.size() - idx), 64'(4));
        if (gnt_port_q.size() >= idx + 4) begin
            for (int k = 0; k < 4; k++)
                check("rr_gnt_order", 64'(gnt_port_q[idx+k]), 64'(k % 2));
            for (int k = 0; k < 3; k++)
                check("rr_gnt_spacing", 64'(gnt_cyc_q[idx+k+1] - gnt_cyc_q[idx+k]), 64'(2 + RD_LAT));
        end
        wait_drain();

        // Address boundaries 127 and 0.
        @(posedge clka);
        #1;
        req_port(0, 1'b1, 7'd127, 32'h0000_007F, 1'b0);
        req_port(0, 1'b1, 7'd0,   32'h0000_0001, 1'b0);
        req_port(1, 1'b0, 7'd127, 32'h0, 1'b1);
        req_port(0, 1'b0, 7'd0,   32'h0, 1'b1);
        wait_drain();

        // Reset during the WAIT cycle of an m1 read, with m0 pending.
        @(posedge clka);
        #1;
        req_port(1, 1'b0, 7'd127, 32'h0, 1'b0);
        drive(0, 1'b0, 7'd0, 32'h0, 1'b1);
        @(posedge clka);
        #1 rsta = 1'b1;
        @(negedge clka);
        check("pre_abort_rdata", 64'(bus.m1_rdata), 64'(32'h0000_007F));
        @(negedge clka);
        check("abort_ctrl", 64'({bus.m0_gnt, bus.m1_gnt, bus.m1_rvalid, bus.ram_wea, bus.busy}), 64'(0));
        check("abort_rdata", 64'(bus.m1_rdata), 64'(0));
        @(posedge clka);
        #1 rsta = 1'b0;
        @(negedge clka);
        check("abort_rel_gnt", 64'({bus.m0_gnt, bus.m1_gnt}), 64'(2'b10));
        drop(0);
        wait_drain();

        // Fixed priority: both ports request writes continuously.
        @(posedge clka);
        #1;
        bus_fp.m0_addr = 7'd1; bus_fp.m0_wdata = 32'h1;
        bus_fp.m1_addr = 7'd2; bus_fp.m1_wdata = 32'h2;
        bus_fp.m0_req = 1'b1;
        bus_fp.m1_req = 1'b1;
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 30 && n0 < 4; i++) begin
            @(negedge clka);
            if (bus_fp.m0_gnt) n0++;
            if (bus_fp.m1_gnt) n1++;
        end
        @(posedge clka);
        #1;
        bus_fp.m0_req = 1'b0;
        bus_fp.m1_req = 1'b0;
        check("fp_m0_grants", 64'(n0), 64'(4));
        check("fp_m1_grants", 64'(n1), 64'(0));

        repeat (4) @(negedge clka);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Two-requester arbiter and sequencer for the 128 x 32 single-port block RAM (`clka`, `wea[0:0]`, `addra[6:0]`, `dina[31:0]`, `douta[31:0]`) used by the pipelined MIPS core. It shares the RAM between the core's memory stage (port m0) and a loader/debug port (m1). Each transaction gets round-robin or fixed-priority arbitration. All RAM-side signals come from registers so the RAM's setup (0.45 ns) and hold (2.9 ns) margins are met. Read data is returned after a parameterised RAM latency.

## Interface
- `AW`, 7, RAM address width
- `DW`, 32, RAM data width
- `RD_LAT`, 1, RAM read latency in cycles (legal 1..4)
- `FIXED_PRIO`, 0, 1 = m0 always wins; 0 = round-robin
- `clka` in 1, single clock, all logic on rising edge
- `rsta` in 1, synchronous active-high reset
- `m0_req` in 1, request; hold with fields stable until `m0_gnt`
- `m0_we` in 1, 1 = write, 0 = read
- `m0_addr` in AW, word address
- `m0_wdata` in DW, write data
- `m0_gnt` out 1, combinational one-cycle accept pulse
- `m0_rvalid` out 1, registered one-cycle read-data pulse
- `m0_rdata` out DW, read data, held until next m0 read completes
- `m1_*`, same seven signals for requester 1
- `ram_wea` out 1, to RAM `wea`
- `ram_addra` out AW, to RAM `addra`
- `ram_dina` out DW, to RAM `dina`
- `ram_douta` in DW, from RAM `douta`
- `busy` out 1, high whenever the FSM is not in IDLE

## Operation
- **One transaction in flight.** No pipelining of requests.
- **IDLE**
  - Grant when any `req` is high and `rsta` is low.
  - Only one `gnt` may be high in a cycle.
  - Capture `we`, `addr`, `wdata` and the port id at the clock edge; go to ACCESS.
- **ACCESS** (1 cycle)
  - `ram_addra`/`ram_dina` come from registers.
  - `ram_wea` = captured `we`.
  - Write → IDLE. Read → WAIT and load the counter with `RD_LAT`.
- **WAIT** (`RD_LAT` cycles)
  - Decrement the counter each cycle.
  - On the last WAIT cycle, register `ram_douta` into the owning port's `rdata`, pulse its `rvalid` next cycle, and go to IDLE.
- **Round-robin** (`FIXED_PRIO`=0)
  - A `last` register records the port of the most recent grant; reset value 1, so m0 wins the first contention.
  - On simultaneous requests, grant `!last`.
  - A sole requester is always granted.
- **Fixed priority** (`FIXED_PRIO`=1): m0 wins any contention.
- **Held RAM signals**
  - `ram_wea` is 0 outside ACCESS-write.
  - `ram_addra`/`ram_dina` hold their last value (no toggling) outside ACCESS.
- **Reset values**
  - All outputs are 0: `gnt`, `rvalid`, `rdata`, `ram_*`, `busy`.
  - FSM = IDLE, counter = 0, `last` = 1.
  - `gnt` is gated low while `rsta` is high.
- **Reset mid-operation**
  - The FSM goes to IDLE at the next edge and `ram_wea` drops.
  - An aborted read produces no `rvalid`; `rdata` is cleared.
- **Addresses** are AW bits with no wrap logic; 127 and 0 are distinct words.
- **Write-then-read** to the same address in consecutive transactions returns the new data.

## Timing
- **Read**: `gnt` in cycle 0, ACCESS in cycle 1, WAIT in cycles 2..1+`RD_LAT`, `rvalid` in cycle 2+`RD_LAT`.
- **Read occupancy**: the next grant is possible in cycle 2+`RD_LAT`, the same cycle as `rvalid`.
- **Write**: `gnt` in cycle 0, `ram_wea`=1 in cycle 1 only, next grant possible in cycle 2.
- **Sustained throughput**: reads 1 per 2+`RD_LAT` cycles; writes 1 per 2 cycles.
- **RAM-side hold**: all RAM-side outputs change only on the `clka` edge that enters or leaves ACCESS, so `ram_addra` is stable for a full period around the RAM capture edge.
- **`busy`**: high from cycle 1 through the last ACCESS/WAIT cycle.
- **RAM startup**: `ram_douta` is sampled only on the last WAIT cycle. Its forced-zero output during FPGA global reset (first 100 ns) is never sampled because `rsta` covers that window.

## Test plan
- **Reset**: `rsta`=1 for 3 cycles with both `req`=1 → `gnt`=0; all outputs 0 throughout and one cycle after release; m0 granted in the first cycle with `rsta`=0.
- **Write then read, m0** (`RD_LAT`=1):
  - Write addr 5, data 32'hDEADBEEF → `ram_wea`=1 for exactly one cycle with `ram_addra`=5.
  - Then read addr 5 → `m0_rvalid` 3 cycles after `gnt`, `m0_rdata`=32'hDEADBEEF.
- **Contention**: both ports read simultaneously, twice back-to-back → grant order m0, m1, m0, m1; grants spaced 3 cycles apart; each `rvalid` goes only to its owner.
- **Address boundaries**: write 32'h0000_007F to addr 127 and 32'h1 to addr 0 → reads return the matching values with no aliasing.
- **Reset mid-read**: assert `rsta` in the WAIT cycle of an m1 read → no `m1_rvalid`, `m1_rdata`=0, `ram_wea`=0; a pending m0 request is granted the first cycle after release.
- **Fixed priority**: `FIXED_PRIO`=1, both ports request continuously for 4 grants → all grants to m0, none to m1.
